bus_master_if: RTL and testbench

//  CPU-side bus master adapter sitting directly upstream of the 8-slave bus mux. Accepts one

---
 rtl/bus_master_if.sv | 162 ++++++++++++++++
 tb/tb_bus_master_if.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// CPU-side bus master: one outstanding load/store, one-hot slave select.
// Optional abort of stuck cycles when BUS_TIMEOUT_EN is defined.
module bus_master_if #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int SW             = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_ce_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  input  logic          hold_i,
  input  logic          flush_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          cpu_err_o,
  output logic          stallreq_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_we_o,
  output logic [SW-1:0] m_select_o,
  input  logic [DW-1:0] m_data_i,
  input  logic          m_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_STALL
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_data_q;
  logic          m_we_q;
  logic [SW-1:0] m_sel_q;
  logic [DW-1:0] rd_buf_q;

  logic [3:0]    region;
  logic          req_ok;
  logic          req_bad;
  logic          ack_ok;
  logic          tmo;
  logic          bus_end;
  logic [DW-1:0] ack_data;

  assign region   = cpu_addr_i[AW-1:AW-4];
  assign req_ok   = (state_q == IDLE) && cpu_ce_i
                    && !flush_i && !region[3];
  assign req_bad  = (state_q == IDLE) && cpu_ce_i
                    && !flush_i && region[3];
  assign ack_ok   = (state_q == BUSY) && !flush_i && m_ack_i;
  assign ack_data = m_we_q ? '0 : m_data_i;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q;

  assign tmo = (state_q == BUSY) && !flush_i && !m_ack_i
               && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles without ack; restart on every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (req_ok) begin
      cnt_q <= '0;
    end else if ((state_q == BUSY) && !m_ack_i && !flush_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign unused_tmo = ^8'(TIMEOUT_CYCLES);
`endif

  assign bus_end = (state_q == BUSY) && (flush_i || ack_ok || tmo);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: flush beats ack/timeout, which beat new requests
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_ok) state_d = BUSY;
      end
      BUSY: begin
        if (flush_i)            state_d = IDLE;
        else if (ack_ok || tmo) state_d = hold_i ? WAIT_STALL : IDLE;
      end
      WAIT_STALL: begin
        if (flush_i || !hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus-side registers and read-data buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr_q <= '0;
      m_data_q <= '0;
      m_we_q   <= 1'b0;
      m_sel_q  <= '0;
      rd_buf_q <= '0;
    end else begin
      if (req_ok) begin
        m_addr_q <= cpu_addr_i;
        m_data_q <= cpu_data_i;
        m_we_q   <= cpu_we_i;
        m_sel_q  <= SW'(1) << region;
      end else if (bus_end) begin
        m_we_q   <= 1'b0;
        m_sel_q  <= '0;
      end
      if (ack_ok)   rd_buf_q <= ack_data;
      else if (tmo) rd_buf_q <= '0;
    end
  end

  // Pipeline-side outputs are combinational from state and bus inputs
  always_comb begin
    stallreq_o = 1'b0;
    cpu_err_o  = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          stallreq_o = req_ok;
          cpu_err_o  = req_bad;
        end
        BUSY: begin
          if (!flush_i) begin
            if (ack_ok)   cpu_data_o = ack_data;
            else if (tmo) cpu_err_o  = 1'b1;
            else          stallreq_o = 1'b1;
          end
        end
        WAIT_STALL: begin
          cpu_data_o = rd_buf_q;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  assign m_addr_o   = m_addr_q;
  assign m_data_o   = m_data_q;
  assign m_we_o     = m_we_q;
  assign m_select_o = m_sel_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] cpu_data_o;
  logic        cpu_err_o;
  logic        stallreq_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_we_o;
  logic [15:0] m_select_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_master_if #(
    .DW(32), .AW(32), .SW(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .cpu_data_o (cpu_data_o),
    .cpu_err_o  (cpu_err_o),
    .stallreq_o (stallreq_o),
    .m_addr_o   (m_addr_o),
    .m_data_o   (m_data_o),
    .m_we_o     (m_we_o),
    .m_select_o (m_select_o),
    .m_data_i   (m_data_i),
    .m_ack_i    (m_ack_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiet();
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    hold_i     = 1'b0;
    flush_i    = 1'b0;
    m_data_i   = '0;
    m_ack_i    = 1'b0;
  endtask

  task automatic req(input logic we,
                     input logic [31:0] a,
                     input logic [31:0] d);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = a;
    cpu_data_i = d;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    nxt();
    nxt();
    mid();
    chk("rst_sel",  32'(m_select_o), 32'h0);
    chk("rst_we",   32'(m_we_o),     32'h0);
    chk("rst_addr", m_addr_o,        32'h0);
    chk("rst_mdat", m_data_o,        32'h0);
    chk("rst_stl",  32'(stallreq_o), 32'h0);
    chk("rst_err",  32'(cpu_err_o),  32'h0);
    chk("rst_dat",  cpu_data_o,      32'h0);
    nxt();
    rst = 1'b0;

    // 1: read slave 2, ack in third BUSY cycle
    req(1'b0, 32'h2000_0010, 32'h0);
    mid();
    chk("t1_req_stl", 32'(stallreq_o), 32'h1);
    chk("t1_req_sel", 32'(m_select_o), 32'h0);
    nxt();
    quiet();
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t1_b_sel", 32'(m_select_o), 32'h4);
      chk("t1_b_stl", 32'(stallreq_o), 32'h1);
      chk("t1_b_adr", m_addr_o,        32'h2000_0010);
      nxt();
    end
    m_ack_i  = 1'b1;
    m_data_i = 32'hDEAD_BEEF;
    mid();
    chk("t1_a_sel", 32'(m_select_o), 32'h4);
    chk("t1_a_stl", 32'(stallreq_o), 32'h0);
    chk("t1_a_dat", cpu_data_o,      32'hDEAD_BEEF);
    nxt();
    quiet();
    mid();
    chk("t1_e_sel", 32'(m_select_o), 32'h0);
    chk("t1_e_stl", 32'(stallreq_o), 32'h0);

    // 2: write slave 0, ack in first BUSY cycle
    req(1'b1, 32'h0000_0004, 32'h1234_5678);
    mid();
    chk("t2_req_stl", 32'(stallreq_o), 32'h1);
    nxt();
    quiet();
    m_ack_i  = 1'b1;
    m_data_i = 32'hFFFF_FFFF;
    mid();
    chk("t2_sel",  32'(m_select_o), 32'h1);
    chk("t2_we",   32'(m_we_o),     32'h1);
    chk("t2_mdat", m_data_o,        32'h1234_5678);
    chk("t2_stl",  32'(stallreq_o), 32'h0);
    chk("t2_dat",  cpu_data_o,      32'h0);
    nxt();
    quiet();
    mid();
    chk("t2_e_sel", 32'(m_select_o), 32'h0);
    chk("t2_e_we",  32'(m_we_o),     32'h0);

    // 3: unmapped region
    req(1'b0, 32'h9000_0000, 32'h0);
    m_data_i = 32'hAAAA_5555;
    mid();
    chk("t3_err", 32'(cpu_err_o),  32'h1);
    chk("t3_dat", cpu_data_o,      32'h0);
    chk("t3_stl", 32'(stallreq_o), 32'h0);
    nxt();
    quiet();
    mid();
    chk("t3_sel",   32'(m_select_o), 32'h0);
    chk("t3_err_e", 32'(cpu_err_o),  32'h0);

    // 4: read slave 7 with hold, pending request held off
    req(1'b0, 32'h7000_0000, 32'h0);
    nxt();
    quiet();
    m_ack_i  = 1'b1;
    m_data_i = 32'hCAFE_0001;
    hold_i   = 1'b1;
    mid();
    chk("t4_a_sel", 32'(m_select_o), 32'h80);
    chk("t4_a_dat", cpu_data_o,      32'hCAFE_0001);
    nxt();
    m_ack_i  = 1'b0;
    m_data_i = '0;
    req(1'b0, 32'h1000_0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_w_dat", cpu_data_o,      32'hCAFE_0001);
      chk("t4_w_stl", 32'(stallreq_o), 32'h0);
      chk("t4_w_sel", 32'(m_select_o), 32'h0);
      nxt();
    end
    hold_i = 1'b0;
    mid();
    chk("t4_rel_stl", 32'(stallreq_o), 32'h0);
    nxt();
    mid();
    chk("t4_new_stl", 32'(stallreq_o), 32'h1);
    nxt();
    quiet();
    m_ack_i = 1'b1;
    mid();
    chk("t4_new_sel", 32'(m_select_o), 32'h2);
    nxt();
    quiet();

    // 5a: flush with simultaneous ack in second BUSY cycle
    req(1'b0, 32'h3000_0000, 32'h0);
    nxt();
    quiet();
    nxt();
    m_ack_i  = 1'b1;
    m_data_i = 32'h0000_0055;
    flush_i  = 1'b1;
    mid();
    chk("t5_f_stl", 32'(stallreq_o), 32'h0);
    chk("t5_f_err", 32'(cpu_err_o),  32'h0);
    chk("t5_f_sel", 32'(m_select_o), 32'h8);
    nxt();
    quiet();
    mid();
    chk("t5_e_sel", 32'(m_select_o), 32'h0);
    chk("t5_e_stl", 32'(stallreq_o), 32'h0);
    chk("t5_e_dat", cpu_data_o,      32'h0);

    // 5b: reset in the middle of a write
    req(1'b1, 32'h1000_0020, 32'h0BAD_F00D);
    nxt();
    quiet();
    mid();
    chk("t5_r_sel0", 32'(m_select_o), 32'h2);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    mid();
    chk("t5_r_sel",  32'(m_select_o), 32'h0);
    chk("t5_r_we",   32'(m_we_o),     32'h0);
    chk("t5_r_addr", m_addr_o,        32'h0);
    chk("t5_r_mdat", m_data_o,        32'h0);
    chk("t5_r_stl",  32'(stallreq_o), 32'h0);
    nxt();

    // 6: no ack
    req(1'b0, 32'h5000_0000, 32'h0);
    nxt();
    quiet();
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t6_b_stl", 32'(stallreq_o), 32'h1);
      chk("t6_b_err", 32'(cpu_err_o),  32'h0);
      nxt();
    end
    mid();
    chk("t6_t_err", 32'(cpu_err_o),  32'h1);
    chk("t6_t_stl", 32'(stallreq_o), 32'h0);
    chk("t6_t_dat", cpu_data_o,      32'h0);
    chk("t6_t_sel", 32'(m_select_o), 32'h20);
    nxt();
    mid();
    chk("t6_e_sel", 32'(m_select_o), 32'h0);
    chk("t6_e_err", 32'(cpu_err_o),  32'h0);
`else
    for (int i = 0; i < 100; i++) begin
      mid();
      chk("t6_stl", 32'(stallreq_o), 32'h1);
      chk("t6_err", 32'(cpu_err_o),  32'h0);
      nxt();
    end
    mid();
    chk("t6_sel", 32'(m_select_o), 32'h20);
    nxt();
    flush_i = 1'b1;
    nxt();
    flush_i = 1'b0;
    mid();
    chk("t6_e_sel", 32'(m_select_o), 32'h0);
`endif
    nxt();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
